// File: rtl/zeroheti_pkg.sv
// zeroHETI shared definitions: subordinate indices and data-side address map.
// Rules are derived from the region map so base/size edits stay in one place.
package zeroheti_pkg;

  localparam int unsigned NumSbr = 8;

  typedef enum logic [2:0] {
    SbrDbg,
    SbrImem,
    SbrDmem,
    SbrHetic,
    SbrUart,
    SbrI2c,
    SbrMtimer,
    SbrExt
  } sbr_idx_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] size;
  } addr_region_t;

  typedef addr_region_t [NumSbr-1:0] addr_map_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  typedef addr_rule_t [NumSbr-1:0] addr_rules_t;

  localparam logic [31:0] ImemSize = 32'h0000_8000;
  localparam logic [31:0] DmemSize = 32'h0000_8000;

  function automatic addr_map_t default_addr_map();
    addr_map_t m;
    m[SbrDbg]    = '{base: 32'h0000_0000, size: 32'h0000_1000};
    m[SbrImem]   = '{base: 32'h0001_0000, size: ImemSize};
    m[SbrDmem]   = '{base: 32'h0002_0000, size: DmemSize};
    m[SbrHetic]  = '{base: 32'h0000_1000, size: 32'h0000_1000};
    m[SbrUart]   = '{base: 32'h0000_2000, size: 32'h0000_0100};
    m[SbrI2c]    = '{base: 32'h0000_2200, size: 32'h0000_0100};
    m[SbrMtimer] = '{base: 32'h0000_2100, size: 32'h0000_0100};
    m[SbrExt]    = '{base: 32'h8000_0000, size: 32'h8000_0000};
    return m;
  endfunction

  // A region ending exactly at 2^32 maps to last = FFFF_FFFF (inclusive)
  function automatic addr_rules_t addr_map_to_rules(addr_map_t m);
    addr_rules_t r;
    logic [32:0] end_addr;
    for (int i = 0; i < NumSbr; i++) begin
      end_addr = {1'b0, m[i].base} + {1'b0, m[i].size};
      r[i].base = m[i].base;
      r[i].last = end_addr[32] ? 32'hFFFF_FFFF : end_addr[31:0];
    end
    return r;
  endfunction

  localparam addr_map_t   AddrMap  = default_addr_map();
  localparam addr_rules_t SbrRules = addr_map_to_rules(AddrMap);

endpackage

// File: rtl/zeroheti_addr_decode.sv
// Combinational address decoder: lowest matching rule index wins.
// Shared by the data-side demux and the instruction-side path.
module zeroheti_addr_decode
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumRules = NumSbr,
  parameter addr_rule_t [NumRules-1:0] Rules = SbrRules,
  localparam int unsigned IdxW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic [31:0]     i_addr,
  output logic [IdxW-1:0] o_idx,
  output logic            o_hit
);

  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    // Walk high to low so the lowest overlapping index is the last written
    for (int i = NumRules - 1; i >= 0; i--) begin
      if ((i_addr >= Rules[i].base) &&
          ((i_addr < Rules[i].last) ||
           (Rules[i].last == 32'hFFFF_FFFF))) begin
        o_idx = IdxW'(i);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zeroheti_obi_demux.sv
// Data-side OBI demux: single-target in-order tracking, local error target.
// Optional error log ports under `ZEROHETI_DEMUX_ERRLOG_EN.
module zeroheti_obi_demux #(
  parameter int unsigned NumSbr   = zeroheti_pkg::NumSbr,
  parameter int unsigned MaxTrans = 2,
  parameter zeroheti_pkg::addr_rule_t [NumSbr-1:0] Rules =
    zeroheti_pkg::SbrRules
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
  output logic [31:0]            err_addr_o,
  output logic [7:0]             err_cnt_o,
`endif
  output logic [NumSbr-1:0]      sbr_req_o,
  input  logic [NumSbr-1:0]      sbr_gnt_i,
  output logic [31:0]            sbr_addr_o,
  output logic                   sbr_we_o,
  output logic [3:0]             sbr_be_o,
  output logic [31:0]            sbr_wdata_o,
  input  logic [NumSbr-1:0]      sbr_rvalid_i,
  input  logic [NumSbr-1:0][31:0] sbr_rdata_i,
  input  logic [NumSbr-1:0]      sbr_err_i
);

  localparam int unsigned IdxW = (NumSbr > 1) ? $clog2(NumSbr) : 1;
  localparam int unsigned TgtW = $clog2(NumSbr + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [TgtW-1:0] TgtErr = TgtW'(NumSbr);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  logic [IdxW-1:0]   w_idx;
  logic              w_hit;
  logic [TgtW-1:0]   w_dec_tgt;
  logic [TgtW-1:0]   r_tgt;
  logic [CntW-1:0]   r_cnt;
  logic              w_busy;
  logic              w_allow;
  logic              w_tgt_err;
  logic [IdxW-1:0]   w_tgt_idx;
  logic [NumSbr-1:0] w_rv_mask;

  zeroheti_addr_decode #(
    .NumRules (NumSbr),
    .Rules    (Rules)
  ) i_dec (
    .i_addr (addr_i),
    .o_idx  (w_idx),
    .o_hit  (w_hit)
  );

  assign w_dec_tgt = w_hit ? TgtW'(w_idx) : TgtErr;
  assign w_busy    = r_cnt != '0;
  assign w_tgt_err = r_tgt == TgtErr;
  assign w_tgt_idx = r_tgt[IdxW-1:0];

  // Only one target may be in flight, so responses can never reorder
  assign w_allow = req_i & ~rst_i &
                   (~w_busy | ((r_cnt < CntMax) & (w_dec_tgt == r_tgt)));

  assign gnt_o = w_allow & (w_hit ? sbr_gnt_i[w_idx] : 1'b1);

  always_comb begin
    sbr_req_o = '0;
    if (w_allow & w_hit) sbr_req_o[w_idx] = 1'b1;
  end

  assign sbr_addr_o  = addr_i;
  assign sbr_we_o    = we_i;
  assign sbr_be_o    = be_i;
  assign sbr_wdata_o = wdata_i;

  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (w_busy) begin
      if (w_tgt_err) begin
        rvalid_o = 1'b1;
        err_o    = 1'b1;
      end else begin
        rvalid_o = sbr_rvalid_i[w_tgt_idx];
        rdata_o  = sbr_rdata_i[w_tgt_idx];
        err_o    = sbr_err_i[w_tgt_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_tgt <= TgtErr;
    end else begin
      if (gnt_o) r_tgt <= w_dec_tgt;
      if (gnt_o & ~rvalid_o)
        r_cnt <= r_cnt + CntW'(1);
      else if (~gnt_o & rvalid_o)
        r_cnt <= r_cnt - CntW'(1);
    end
  end

`ifdef ZEROHETI_DEMUX_ERRLOG_EN
  logic [31:0] r_err_addr;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (gnt_o & ~w_hit) begin
      r_err_addr <= addr_i;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_addr_o = r_err_addr;
  assign err_cnt_o  = r_err_cnt;
`endif

  always_comb begin
    w_rv_mask = '0;
    if (w_busy & ~w_tgt_err) w_rv_mask[w_tgt_idx] = 1'b1;
  end

  a_stray_rvalid : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (sbr_rvalid_i & ~w_rv_mask) == '0
  );

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// Bench for zeroheti_obi_demux: directed corners, decode table, random run.
// Error-log checks are active when ZEROHETI_DEMUX_ERRLOG_EN is defined.
module tb_zeroheti_obi_demux;

  localparam int NS  = 8;
  localparam int MT  = 2;
  localparam int ERR = 8;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                req_i;
  logic                gnt_o;
  logic [31:0]         addr_i;
  logic                we_i;
  logic [3:0]          be_i;
  logic [31:0]         wdata_i;
  logic                rvalid_o;
  logic [31:0]         rdata_o;
  logic                err_o;
  logic [NS-1:0]       sbr_req_o;
  logic [NS-1:0]       sbr_gnt_i;
  logic [31:0]         sbr_addr_o;
  logic                sbr_we_o;
  logic [3:0]          sbr_be_o;
  logic [31:0]         sbr_wdata_o;
  logic [NS-1:0]       sbr_rvalid_i;
  logic [NS-1:0][31:0] sbr_rdata_i;
  logic [NS-1:0]       sbr_err_i;
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
  logic [31:0]         err_addr_o;
  logic [7:0]          err_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  zeroheti_obi_demux #(
    .MaxTrans (MT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
    .err_addr_o   (err_addr_o),
    .err_cnt_o    (err_cnt_o),
`endif
    .sbr_req_o    (sbr_req_o),
    .sbr_gnt_i    (sbr_gnt_i),
    .sbr_addr_o   (sbr_addr_o),
    .sbr_we_o     (sbr_we_o),
    .sbr_be_o     (sbr_be_o),
    .sbr_wdata_o  (sbr_wdata_o),
    .sbr_rvalid_i (sbr_rvalid_i),
    .sbr_rdata_i  (sbr_rdata_i),
    .sbr_err_i    (sbr_err_i)
  );

  int n_check = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic idle();
    req_i        = 1'b0;
    we_i         = 1'b0;
    be_i         = 4'hF;
    wdata_i      = '0;
    sbr_gnt_i    = '1;
    sbr_rvalid_i = '0;
    sbr_err_i    = '0;
  endtask

  // Address map written as plain ranges, checked in index order
  function automatic int ref_dec(logic [31:0] a);
    if (a < 32'h1000) return 0;
    if (a >= 32'h1_0000 && a < 32'h1_8000) return 1;
    if (a >= 32'h2_0000 && a < 32'h2_8000) return 2;
    if (a >= 32'h1000 && a < 32'h2000) return 3;
    if (a >= 32'h2000 && a < 32'h2100) return 4;
    if (a >= 32'h2200 && a < 32'h2300) return 5;
    if (a >= 32'h2100 && a < 32'h2200) return 6;
    if (a >= 32'h8000_0000) return 7;
    return ERR;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  req;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vec[17];

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        e;
  } sr_t;

  int          rq[$];
  sr_t         sq[$];
  logic [31:0] pool[12];

  initial begin
    vec[0]  = '{32'h0000_0000, 8'h01, 32'hA000_0000, 1'b0};
    vec[1]  = '{32'h0000_0FFF, 8'h01, 32'hA000_0000, 1'b0};
    vec[2]  = '{32'h0000_1000, 8'h08, 32'hA000_0003, 1'b0};
    vec[3]  = '{32'h0000_1FFF, 8'h08, 32'hA000_0003, 1'b0};
    vec[4]  = '{32'h0000_2000, 8'h10, 32'hA000_0004, 1'b0};
    vec[5]  = '{32'h0000_20FF, 8'h10, 32'hA000_0004, 1'b0};
    vec[6]  = '{32'h0000_2100, 8'h40, 32'hA000_0006, 1'b0};
    vec[7]  = '{32'h0000_2200, 8'h20, 32'hA000_0005, 1'b0};
    vec[8]  = '{32'h0000_2300, 8'h00, 32'h0000_0000, 1'b1};
    vec[9]  = '{32'h0001_0000, 8'h02, 32'hA000_0001, 1'b0};
    vec[10] = '{32'h0001_7FFC, 8'h02, 32'hA000_0001, 1'b0};
    vec[11] = '{32'h0001_8000, 8'h00, 32'h0000_0000, 1'b1};
    vec[12] = '{32'h0002_0000, 8'h04, 32'hA000_0002, 1'b0};
    vec[13] = '{32'h0002_8000, 8'h00, 32'h0000_0000, 1'b1};
    vec[14] = '{32'h7FFF_FFFF, 8'h00, 32'h0000_0000, 1'b1};
    vec[15] = '{32'h8000_0000, 8'h80, 32'hA000_0007, 1'b0};
    vec[16] = '{32'hFFFF_FFFF, 8'h80, 32'hA000_0007, 1'b0};

    pool = '{32'h0, 32'hFFC, 32'h1000, 32'h2000, 32'h2100, 32'h2200,
             32'h2300, 32'h1_0000, 32'h1_8000, 32'h2_0000, 32'h2_0004,
             32'hFFFF_FFFF};

    idle();
    rst_i = 1'b1;
    addr_i = 32'h0001_0004;
    for (int k = 0; k < NS; k++) sbr_rdata_i[k] = '0;

    // reset behaviour
    tick();
    req_i = 1'b1;
    smp();
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_sbr_req", sbr_req_o, 8'h00);
    tick();
    rst_i = 1'b0;
    req_i = 1'b0;
    smp();
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
    chk("rst_err_cnt", err_cnt_o, 8'h00);
    chk("rst_err_addr", err_addr_o, 32'h0);
`endif

    // unmapped request
    tick();
    req_i = 1'b1;
    addr_i = 32'h0000_2300;
    smp();
    chk("unm_gnt", gnt_o, 1'b1);
    chk("unm_sbr_req", sbr_req_o, 8'h00);
    tick();
    req_i = 1'b0;
    smp();
    chk("unm_rvalid", rvalid_o, 1'b1);
    chk("unm_err", err_o, 1'b1);
    chk("unm_rdata", rdata_o, 32'h0);
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
    chk("unm_err_addr", err_addr_o, 32'h0000_2300);
    chk("unm_err_cnt", err_cnt_o, 8'h01);
`endif
    tick();
    smp();
    chk("unm_rvalid_end", rvalid_o, 1'b0);

    // imem read, response two cycles after grant
    tick();
    req_i = 1'b1;
    addr_i = 32'h0001_0004;
    smp();
    chk("imem_gnt", gnt_o, 1'b1);
    chk("imem_sbr_req", sbr_req_o, 8'h02);
    tick();
    req_i = 1'b0;
    smp();
    chk("imem_no_rv", rvalid_o, 1'b0);
    tick();
    sbr_rvalid_i[1] = 1'b1;
    sbr_rdata_i[1] = 32'hDEAD_BEEF;
    smp();
    chk("imem_rvalid", rvalid_o, 1'b1);
    chk("imem_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("imem_err", err_o, 1'b0);
    tick();
    sbr_rvalid_i = '0;
    smp();
    chk("imem_rv_once", rvalid_o, 1'b0);

    // subordinate withholds grant
    tick();
    req_i = 1'b1;
    addr_i = 32'h0001_0000;
    sbr_gnt_i = '0;
    smp();
    chk("sgnt_low_gnt", gnt_o, 1'b0);
    chk("sgnt_low_req", sbr_req_o, 8'h02);
    tick();
    sbr_gnt_i = '1;
    smp();
    chk("sgnt_hi_gnt", gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
    sbr_rvalid_i[1] = 1'b1;
    sbr_rdata_i[1] = 32'h0000_0005;
    smp();
    chk("sgnt_rdata", rdata_o, 32'h5);
    tick();
    idle();

    // back-to-back dmem, third stalls at MaxTrans
    req_i = 1'b1;
    addr_i = 32'h0002_0000;
    smp();
    chk("dm0_gnt", gnt_o, 1'b1);
    tick();
    addr_i = 32'h0002_0004;
    smp();
    chk("dm1_gnt", gnt_o, 1'b1);
    tick();
    addr_i = 32'h0002_0008;
    smp();
    chk("dm2_stall_gnt", gnt_o, 1'b0);
    chk("dm2_stall_req", sbr_req_o, 8'h00);
    tick();
    sbr_rvalid_i[2] = 1'b1;
    sbr_rdata_i[2] = 32'h1111_1111;
    smp();
    chk("dm0_rdata", rdata_o, 32'h1111_1111);
    chk("dm2_pop_gnt", gnt_o, 1'b0);
    tick();
    sbr_rvalid_i[2] = 1'b0;
    smp();
    chk("dm2_gnt", gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
    sbr_rvalid_i[2] = 1'b1;
    sbr_rdata_i[2] = 32'h2222_2222;
    smp();
    chk("dm1_rdata", rdata_o, 32'h2222_2222);
    tick();
    sbr_rdata_i[2] = 32'h3333_3333;
    smp();
    chk("dm2_rvalid", rvalid_o, 1'b1);
    chk("dm2_rdata", rdata_o, 32'h3333_3333);
    tick();
    sbr_rvalid_i = '0;
    smp();
    chk("dm_drained", rvalid_o, 1'b0);

    // uart outstanding blocks mtimer
    tick();
    req_i = 1'b1;
    addr_i = 32'h0000_2000;
    smp();
    chk("uart_gnt", gnt_o, 1'b1);
    chk("uart_req", sbr_req_o, 8'h10);
    tick();
    addr_i = 32'h0000_2100;
    smp();
    chk("mt_stall0", gnt_o, 1'b0);
    chk("mt_stall_req", sbr_req_o, 8'h00);
    tick();
    smp();
    chk("mt_stall1", gnt_o, 1'b0);
    tick();
    sbr_rvalid_i[4] = 1'b1;
    sbr_rdata_i[4] = 32'h0000_0044;
    smp();
    chk("uart_rdata", rdata_o, 32'h44);
    chk("mt_stall2", gnt_o, 1'b0);
    tick();
    sbr_rvalid_i = '0;
    smp();
    chk("mt_gnt", gnt_o, 1'b1);
    chk("mt_req", sbr_req_o, 8'h40);
    tick();
    req_i = 1'b0;
    sbr_rvalid_i[6] = 1'b1;
    sbr_rdata_i[6] = 32'h0000_0066;
    smp();
    chk("mt_rdata", rdata_o, 32'h66);
    tick();
    idle();
    smp();
    chk("mt_drained", rvalid_o, 1'b0);

    // decode table
    for (int k = 0; k < NS; k++) sbr_rdata_i[k] = 32'hA000_0000 | k;
    for (int v = 0; v < 17; v++) begin
      tick();
      idle();
      req_i = 1'b1;
      addr_i = vec[v].addr;
      smp();
      chk($sformatf("tbl%0d_req", v), sbr_req_o, vec[v].req);
      chk($sformatf("tbl%0d_gnt", v), gnt_o, 1'b1);
      tick();
      req_i = 1'b0;
      sbr_rvalid_i = vec[v].req;
      smp();
      chk($sformatf("tbl%0d_rv", v), rvalid_o, 1'b1);
      chk($sformatf("tbl%0d_rdata", v), rdata_o, vec[v].rdata);
      chk($sformatf("tbl%0d_err", v), err_o, vec[v].err);
    end
    tick();
    idle();

    // reset with two outstanding
    req_i = 1'b1;
    addr_i = 32'h0002_0000;
    smp();
    chk("rr0_gnt", gnt_o, 1'b1);
    tick();
    addr_i = 32'h0002_0004;
    smp();
    chk("rr1_gnt", gnt_o, 1'b1);
    tick();
    rst_i = 1'b1;
    addr_i = 32'h0001_0000;
    smp();
    chk("rr_rst_gnt", gnt_o, 1'b0);
    chk("rr_rst_req", sbr_req_o, 8'h00);
    tick();
    rst_i = 1'b0;
    req_i = 1'b0;
    smp();
    chk("rr_rvalid", rvalid_o, 1'b0);
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
    chk("rr_err_cnt", err_cnt_o, 8'h00);
`endif
    tick();
    req_i = 1'b1;
    addr_i = 32'h0001_0004;
    smp();
    chk("rr_imem_gnt", gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
    sbr_rvalid_i[1] = 1'b1;
    sbr_rdata_i[1] = 32'hCAFE_0001;
    smp();
    chk("rr_imem_rv", rvalid_o, 1'b1);
    chk("rr_imem_rdata", rdata_o, 32'hCAFE_0001);
    tick();
    idle();
    smp();
    chk("rr_drained", rvalid_o, 1'b0);

    // randomized run against the queue model
    begin
      int          t;
      bit          drv;
      bit          allow;
      logic        e_gnt;
      logic        e_rv;
      logic        e_err;
      logic [31:0] e_data;
      logic [7:0]  e_req;
      logic [31:0] m_eaddr;
      int          m_ecnt;
      m_eaddr = '0;
      m_ecnt = 0;
      for (int c = 0; c < 3000; c++) begin
        tick();
        req_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) begin
          if ($urandom_range(0, 7) == 0) addr_i = $urandom;
          else addr_i = pool[$urandom_range(0, 11)];
        end
        we_i = 1'($urandom);
        be_i = 4'($urandom);
        wdata_i = $urandom;
        sbr_gnt_i = 8'($urandom);
        sbr_err_i = 8'($urandom);
        sbr_rvalid_i = '0;
        for (int k = 0; k < NS; k++) sbr_rdata_i[k] = $urandom;
        drv = 1'b0;
        if (sq.size() > 0 && $urandom_range(0, 2) != 0) begin
          sbr_rvalid_i[sq[0].k] = 1'b1;
          sbr_rdata_i[sq[0].k] = sq[0].d;
          sbr_err_i[sq[0].k] = sq[0].e;
          drv = 1'b1;
        end
        smp();
        t = ref_dec(addr_i);
        allow = req_i && (rq.size() == 0 ||
                          (rq.size() < MT && rq[0] == t));
        e_req = '0;
        if (allow && t != ERR) e_req[t] = 1'b1;
        e_gnt = allow && (t == ERR || sbr_gnt_i[t]);
        e_rv = 1'b0;
        e_err = 1'b0;
        e_data = '0;
        if (rq.size() > 0) begin
          if (rq[0] == ERR) begin
            e_rv = 1'b1;
            e_err = 1'b1;
          end else if (drv) begin
            e_rv = 1'b1;
            e_err = sq[0].e;
            e_data = sq[0].d;
          end
        end
        chk("rnd_gnt", gnt_o, e_gnt);
        chk("rnd_sbr_req", sbr_req_o, e_req);
        chk("rnd_rvalid", rvalid_o, e_rv);
        if (e_rv) begin
          chk("rnd_rdata", rdata_o, e_data);
          chk("rnd_err", err_o, e_err);
        end
        chk("rnd_bcast", {sbr_we_o, sbr_be_o, sbr_addr_o},
            {we_i, be_i, addr_i});
        chk("rnd_wdata", sbr_wdata_o, wdata_i);
`ifdef ZEROHETI_DEMUX_ERRLOG_EN
        chk("rnd_err_addr", err_addr_o, m_eaddr);
        chk("rnd_err_cnt", err_cnt_o, 8'(m_ecnt));
`endif
        if (e_rv) begin
          if (rq[0] != ERR) void'(sq.pop_front());
          void'(rq.pop_front());
        end
        if (e_gnt) begin
          rq.push_back(t);
          if (t != ERR)
            sq.push_back('{t, $urandom, 1'($urandom)});
          else begin
            m_eaddr = addr_i;
            if (m_ecnt < 255) m_ecnt++;
          end
        end
      end
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
